// File: rtl/adc_cfg_spi_slave_if.sv
// Pad-side and register-side signal bundle of the ADC configuration SPI responder.
// The slave modport is the responder; the master modport is the SPI master plus register observer.
interface adc_cfg_spi_slave_if #(
   parameter int NUM_REGS = 32
) ();
   logic                  SCK;
   logic                  SEN;
   logic                  sdi_in;
   logic                  sdi_out;
   logic                  sdi_oe;
   logic                  reg_wr_stb;
   logic [4:0]            reg_wr_addr;
   logic [7:0]            reg_wr_data;
   logic [NUM_REGS*8-1:0] regs_flat;
   logic                  frame_err;

   modport slave (
      input  SCK, SEN, sdi_in,
      output sdi_out, sdi_oe, reg_wr_stb, reg_wr_addr, reg_wr_data, regs_flat, frame_err
   );

   modport master (
      output SCK, SEN, sdi_in,
      input  sdi_out, sdi_oe, reg_wr_stb, reg_wr_addr, reg_wr_data, regs_flat, frame_err
   );
endinterface

// File: rtl/adc_cfg_spi_slave.sv
// 3-wire SPI responder with an 8-bit register file, oversampling SCK/SEN/SDI in clk_sys.
// Frames are 16 bits MSB first: R/W, 5-bit address, 2 ignored bits, 8 data bits.
module adc_cfg_spi_slave #(
   parameter int NUM_REGS    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_sys,
   input  logic                rst_n,
   adc_cfg_spi_slave_if.slave  bus,
   output logic [2:0]          dbg_state_o
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      WDATA = 3'd2,
      RDATA = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sen_sync_q, sdi_sync_q;
   logic                   sck_prev_q, sen_prev_q;
   logic                   sck_s, sen_s, sdi_s;
   logic                   sck_rise, sck_fall, sen_rise, sen_fall;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [6:0]             sr_q, sr_d;
   logic [7:0]             shift_byte, rd_byte;
   logic [4:0]             addr_q, addr_d;
   logic [7:0]             tx_sr_q, tx_sr_d;
   logic                   sdi_out_q, sdi_out_d, sdi_oe_q, sdi_oe_d;
   logic                   wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
   logic [4:0]             wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic [7:0]             regs_q [NUM_REGS];

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sen_s    = sen_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign sen_rise = sen_s & ~sen_prev_q;
   assign sen_fall = ~sen_s & sen_prev_q;

   // One shift register serves both the header and write data; the address is latched after bit 8.
   assign shift_byte = {sr_q, sdi_s};

   always_comb begin
      rd_byte = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (shift_byte[6:2] == i[4:0]) rd_byte = regs_q[i];
      end
   end

   // reg_wr_stb is a single-cycle strobe; addr/data hold their value until the next commit.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      addr_d      = addr_q;
      tx_sr_d     = tx_sr_q;
      sdi_out_d   = sdi_out_q;
      sdi_oe_d    = sdi_oe_q;
      wr_stb_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      frame_err_d = 1'b0;
      if (sen_rise) begin
         state_d     = IDLE;
         sdi_oe_d    = 1'b0;
         frame_err_d = (state_q != IDLE) && (bit_cnt_q != 5'd16);
      end else if (sen_fall) begin
         state_d   = HDR;
         bit_cnt_d = '0;
         sdi_oe_d  = 1'b0;
      end else if (!sen_s) begin
         case (state_q)
            HDR: if (sck_rise) begin
               sr_d      = shift_byte[6:0];
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd7) begin
                  addr_d = shift_byte[6:2];
                  if (shift_byte[7]) begin
                     tx_sr_d = rd_byte;
                     state_d = RDATA;
                  end else begin
                     state_d = WDATA;
                  end
               end
            end
            WDATA: if (sck_rise) begin
               sr_d      = shift_byte[6:0];
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd15) begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = shift_byte;
                  state_d   = DONE;
               end
            end
            RDATA: begin
               if (sck_fall) begin
                  sdi_oe_d  = 1'b1;
                  sdi_out_d = tx_sr_q[7];
                  tx_sr_d   = {tx_sr_q[6:0], 1'b0};
               end
               if (sck_rise) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd15) state_d = DONE;
               end
            end
            DONE: begin
               if (sck_fall) sdi_oe_d = 1'b0;
               // Overrun edges still count so SEN rise can flag the over-length frame.
               if (sck_rise && bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         sen_sync_q  <= '1;
         sdi_sync_q  <= '0;
         sck_prev_q  <= 1'b0;
         sen_prev_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         sr_q        <= '0;
         addr_q      <= '0;
         tx_sr_q     <= '0;
         sdi_out_q   <= 1'b0;
         sdi_oe_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
         sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], bus.SEN};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi_in};
         sck_prev_q  <= sck_s;
         sen_prev_q  <= sen_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         addr_q      <= addr_d;
         tx_sr_q     <= tx_sr_d;
         sdi_out_q   <= sdi_out_d;
         sdi_oe_q    <= sdi_oe_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         frame_err_q <= frame_err_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_stb_d && wr_addr_d == i[4:0]) regs_q[i] <= wr_data_d;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign bus.regs_flat[8*g +: 8] = regs_q[g];
   end

   assign bus.sdi_out     = sdi_out_q;
   assign bus.sdi_oe      = sdi_oe_q;
   assign bus.reg_wr_stb  = wr_stb_q;
   assign bus.reg_wr_addr = wr_addr_q;
   assign bus.reg_wr_data = wr_data_q;
   assign bus.frame_err   = frame_err_q;
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_adc_cfg_spi_slave.sv
// Directed bench for adc_cfg_spi_slave: bit-banged SPI master, commit scoreboard, register image checks.
module tb_adc_cfg_spi_slave;
   localparam int NUM_REGS = 8;
   localparam int HALF     = 8;  // clk_sys cycles per SCK half period

   logic       clk_sys = 1'b0;
   logic       rst_n   = 1'b0;
   logic [2:0] dbg_state;

   adc_cfg_spi_slave_if #(.NUM_REGS(NUM_REGS)) bus ();

   adc_cfg_spi_slave #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   int          checks   = 0;
   int          failures = 0;
   int          stb_cnt  = 0;
   int          err_cnt  = 0;
   int          nbit     = 0;
   logic [15:0] oe_mask  = '0;
   logic [15:0] rx_bits  = '0;
   logic [12:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every commit strobe must match the oldest expected {addr,data}
   always @(negedge clk_sys) begin
      if (bus.reg_wr_stb) begin
         stb_cnt++;
         if (exp_q.size() == 0) check("commit_unexpected_q_size", exp_q.size(), 1);
         else check("commit", {bus.reg_wr_addr, bus.reg_wr_data}, exp_q.pop_front());
      end
      if (bus.frame_err) err_cnt++;
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic frame_start();
      bus.SEN = 1'b0;
      nbit    = 0;
      oe_mask = '0;
      rx_bits = '0;
      tick(HALF);
   endtask

   task automatic clock_bit(input logic b);
      bus.sdi_in = b;
      tick(HALF);
      if (nbit < 16) begin
         oe_mask[nbit] = bus.sdi_oe;
         rx_bits       = {rx_bits[14:0], bus.sdi_out};
      end
      bus.SCK = 1'b1;
      tick(HALF);
      bus.SCK = 1'b0;
      nbit++;
   endtask

   task automatic frame_end();
      tick(HALF);
      bus.SEN = 1'b1;
      tick(4*HALF);
   endtask

   task automatic send_frame(input logic [15:0] w, input int nbits);
      frame_start();
      for (int i = 0; i < nbits; i++) clock_bit((i < 16) ? w[15-i] : 1'b1);
      frame_end();
   endtask

   int s0, e0;

   initial begin
      bus.SCK    = 1'b0;
      bus.SEN    = 1'b1;
      bus.sdi_in = 1'b0;
      tick(5);
      check("rst_sdi_oe",    bus.sdi_oe, 0);
      check("rst_sdi_out",   bus.sdi_out, 0);
      check("rst_wr_stb",    bus.reg_wr_stb, 0);
      check("rst_frame_err", bus.frame_err, 0);
      check("rst_regs",      bus.regs_flat, 0);
      check("rst_wr_addr",   bus.reg_wr_addr, 0);
      check("rst_wr_data",   bus.reg_wr_data, 0);
      check("rst_state",     dbg_state, 0);
      rst_n = 1'b1;
      tick(5);

      // 1: write addr 1 = 0x65
      s0 = stb_cnt; e0 = err_cnt;
      exp_q.push_back({5'd1, 8'h65});
      send_frame(16'h0465, 16);
      check("t1_stb_cnt", stb_cnt - s0, 1);
      check("t1_wr_addr", bus.reg_wr_addr, 5'd1);
      check("t1_wr_data", bus.reg_wr_data, 8'h65);
      check("t1_reg1",    bus.regs_flat[15:8], 8'h65);
      check("t1_err",     err_cnt - e0, 0);

      // 2: write addr 3 = 0xA5, read it back
      exp_q.push_back({5'd3, 8'hA5});
      send_frame(16'h0CA5, 16);
      s0 = stb_cnt; e0 = err_cnt;
      send_frame(16'h8C00, 16);
      check("t2_rx",      rx_bits[7:0], 8'hA5);
      check("t2_oe_mask", oe_mask, 16'hFF00);
      check("t2_oe_end",  bus.sdi_oe, 0);
      check("t2_stb_cnt", stb_cnt - s0, 0);
      check("t2_err",     err_cnt - e0, 0);

      // 3: out-of-range address 31
      send_frame(16'hFC00, 16);
      check("t3_rx", rx_bits[7:0], 8'h00);
      s0 = stb_cnt;
      exp_q.push_back({5'd31, 8'h5A});
      send_frame(16'h7C5A, 16);
      check("t3_stb_cnt", stb_cnt - s0, 1);
      check("t3_wr_addr", bus.reg_wr_addr, 5'd31);
      check("t3_regs",    bus.regs_flat, 64'h00000000_A5006500);

      // 4: write aborted after 10 bits, aborted read, then a clean frame
      s0 = stb_cnt; e0 = err_cnt;
      send_frame(16'h0211, 10);
      check("t4_stb_cnt", stb_cnt - s0, 0);
      check("t4_err",     err_cnt - e0, 1);
      check("t4_oe",      bus.sdi_oe, 0);
      check("t4_regs",    bus.regs_flat, 64'h00000000_A5006500);
      e0 = err_cnt;
      frame_start();
      for (int i = 0; i < 12; i++) clock_bit(i == 0);
      tick(HALF);
      check("t4_rd_oe_mid", bus.sdi_oe, 1);
      bus.SEN = 1'b1;
      tick(4*HALF);
      check("t4_rd_oe_rel", bus.sdi_oe, 0);
      check("t4_rd_err",    err_cnt - e0, 1);
      s0 = stb_cnt; e0 = err_cnt;
      exp_q.push_back({5'd5, 8'h77});
      send_frame(16'h1477, 16);
      check("t4_next_stb",  stb_cnt - s0, 1);
      check("t4_next_reg5", bus.regs_flat[47:40], 8'h77);
      check("t4_next_err",  err_cnt - e0, 0);

      // 5: 18 SCK pulses in one frame
      s0 = stb_cnt; e0 = err_cnt;
      exp_q.push_back({5'd2, 8'h22});
      send_frame(16'h0822, 18);
      check("t5_stb_cnt", stb_cnt - s0, 1);
      check("t5_wr_data", bus.reg_wr_data, 8'h22);
      check("t5_err",     err_cnt - e0, 1);
      check("t5_regs",    bus.regs_flat, 64'h00007700_A5226500);

      // 6: reset in the middle of a read
      frame_start();
      for (int i = 0; i < 12; i++) clock_bit((i == 0) || (i == 5));
      check("t6_oe_before", bus.sdi_oe, 1);
      rst_n = 1'b0;
      #1;
      check("t6_oe_reset",    bus.sdi_oe, 0);
      check("t6_regs_reset",  bus.regs_flat, 0);
      check("t6_state_reset", dbg_state, 0);
      bus.SEN = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(4);
      exp_q.push_back({5'd0, 8'h3C});
      send_frame(16'h003C, 16);
      check("t6_reg0", bus.regs_flat[7:0], 8'h3C);
      send_frame(16'h8000, 16);
      check("t6_rx",   rx_bits[7:0], 8'h3C);

      // report
      check("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
